song_player: RTL and testbench
==============================

SONG_PLAYER -- requirements
Module: song_player

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of independent buzzer voices.
REQ-002 SHALL have parameter DEPTH, default 64: song memory steps; address width AW = $clog2(DEPTH).
REQ-003 SHALL have parameter NOTE_W, default 6: note code width per channel; code 0 = rest.
REQ-004 SHALL have parameter DUR_W, default 8: step duration width, in tempo ticks; 0 = end-of-song marker.
REQ-005 SHALL have parameter PER_W, default 16: tone half-period counter width.
REQ-006 SHALL have ports:
  - clk  in  1  system clock (internal oscillator, 2.08 MHz nominal).
  - rst  in  1  asynchronous active-high reset.
  - tempo  in  1  one-clk tick from the timer.
  - start  in  1  begin playback from step 0.
  - stop  in  1  abort playback.
  - loop  in  1  repeat the song at its end.
  - wr_en  in  1  song memory write strobe.
  - wr_addr  in  AW  write address.
  - wr_data  in  CHANNELS*NOTE_W+DUR_W  step word: [DUR_W-1:0] duration; channel c note at [DUR_W+c*NOTE_W +: NOTE_W].
  - buzzer  out  CHANNELS  square-wave outputs.
  - busy  out  1  high outside IDLE.
  - done  out  1  one-clk pulse at natural song end.
  - pos  out  AW  current step index.

Function
REQ-007 SHALL implement FSM with states IDLE, FETCH, PLAY.
REQ-008 SHALL accept writes only in IDLE; wr_en outside IDLE SHALL be ignored.
REQ-009 In IDLE, start SHALL set pos=0 and enter FETCH the next cycle; start outside IDLE SHALL be ignored.
REQ-010 FETCH SHALL take 2 cycles (address, then registered read data latched into per-channel note and remaining-duration registers), then enter PLAY.
REQ-011 A fetched duration of 0 SHALL end the song without entering PLAY; buzzers stay low.
REQ-012 In PLAY, each tempo tick SHALL decrement the remaining duration; the tick that takes it from 1 to 0 SHALL advance pos by 1 and enter FETCH.
REQ-013 Advancing past step DEPTH-1 SHALL end the song; pos SHALL NOT wrap silently.
REQ-014 At song end: with loop active, pos=0 and FETCH; otherwise done pulses one cycle and the FSM enters IDLE.
REQ-015 stop SHALL force IDLE and drive all buzzers low on the next cycle from any state; stop SHALL win over start in the same cycle.
REQ-016 Each channel SHALL toggle its buzzer every TONE_HALF_PERIOD[code] clk cycles while in PLAY with nonzero code; a rest or a non-PLAY state SHALL hold the buzzer 0 and the counter 0.
REQ-017 A note load (including the same code on the next step) SHALL clear that channel's counter and output to 0.
REQ-018 The first buzzer rising edge SHALL occur exactly 3+H cycles after start is sampled, where H = half-period of step 0.
REQ-019 A tempo tick coincident with a FETCH cycle SHALL NOT be counted.

Reset
REQ-020 rst SHALL force IDLE, pos=0, buzzer=0, busy=0, done=0, and clear all counters; song memory contents need not be cleared.
REQ-021 rst asserted mid-song SHALL take effect immediately, with no done pulse.

Configuration
REQ-022 With SONG_PLAYER_LOOP_EN defined, the loop input SHALL act per REQ-014; without it, loop SHALL be ignored and every song end SHALL pulse done.

Structure
REQ-023 Package song_pkg SHALL hold the FSM state typedef and the TONE_HALF_PERIOD constant table (code 1 = A3 220 Hz = 4727; equal-tempered upward).
REQ-024 The per-channel oscillator SHALL be sub-module tone_gen, instantiated CHANNELS times in a generate loop.

Verification
REQ-025 Write step0 = {ch0=1, ch1=0, dur=2} and step1 = dur 0; start: buzzer[0] rises 4730 cycles after start, buzzer[1] stays 0, and done pulses after the second tempo tick plus 2 cycles.
REQ-026 Fill all 64 steps with dur=1: after 64 ticks, done pulses with pos=63 and no wrap to step 0.
REQ-027 With the macro defined and loop=1, play a 2-step song: pos sequence 0,1,0,1 with no done pulse; without the macro, done pulses once.
REQ-028 Assert stop and start together mid-PLAY: next cycle is IDLE with buzzer=0 and busy=0.
REQ-029 Assert wr_en during PLAY to the current step: memory is unchanged and the re-read value equals the original.
REQ-030 Pulse rst mid-note: all outputs are 0 within the same cycle, then a start replays correctly from step 0.

Source files
------------

// File: rtl/song_pkg.sv
// ============================================================================
// Module   : song_pkg
// Purpose  : Shared types and constants for the song player: the playback FSM
//            state encoding and the per-note tone half-period table.
// Contents : state_t           - IDLE / FETCH / PLAY
//            TONE_HALF_PERIOD  - half-period in clk cycles (2.08 MHz clock),
//                                code 1 = A3 220 Hz, one semitone per code
//            half_period()     - table lookup that returns 0 (silence) for
//                                codes outside the table
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package song_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_PLAY  = 2'd2
  } state_t;

  localparam int TONE_CODES = 64;

  // round(2.08e6 / (2 * 220 * 2^((code-1)/12))); code 0 is a rest.
  localparam logic [15:0] TONE_HALF_PERIOD [TONE_CODES] = '{
    16'd0,
    16'd4727, 16'd4462, 16'd4212, 16'd3975, 16'd3752, 16'd3541,
    16'd3343, 16'd3155, 16'd2978, 16'd2811, 16'd2653, 16'd2504,
    16'd2364, 16'd2231, 16'd2106, 16'd1988, 16'd1876, 16'd1771,
    16'd1671, 16'd1578, 16'd1489, 16'd1405, 16'd1327, 16'd1252,
    16'd1182, 16'd1115, 16'd1053, 16'd994,  16'd938,  16'd885,
    16'd836,  16'd789,  16'd744,  16'd703,  16'd663,  16'd626,
    16'd591,  16'd558,  16'd526,  16'd497,  16'd469,  16'd443,
    16'd418,  16'd394,  16'd372,  16'd351,  16'd332,  16'd313,
    16'd295,  16'd279,  16'd263,  16'd248,  16'd235,  16'd221,
    16'd209,  16'd197,  16'd186,  16'd176,  16'd166,  16'd157,
    16'd148,  16'd139,  16'd132
  };

  function automatic logic [15:0] half_period(input logic [31:0] code);
    logic [5:0] idx;
    idx = code[5:0];
    if (code >= 32'(TONE_CODES)) return 16'd0;
    return TONE_HALF_PERIOD[idx];
  endfunction

endpackage

`default_nettype wire

// File: rtl/song_player_tone_gen.sv
// ============================================================================
// Module   : tone_gen
// Purpose  : One buzzer voice. Toggles its output every half-period of the
//            current note code while run is high.
// Ports    : clk, rst (async, active high)
//            load   - a new note was latched; restart from a low output
//            run    - the player is (about to be) in PLAY
//            code   - note code, 0 = rest
//            buzzer - square-wave output
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tone_gen #(
  parameter int NOTE_W = 6,
  parameter int PER_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              run,
  input  logic [NOTE_W-1:0] code,
  output logic              buzzer
);
  import song_pkg::*;

  logic [PER_W-1:0] half;
  logic [PER_W-1:0] cnt_d, cnt_q;
  logic             buzzer_d, buzzer_q;

  assign half = PER_W'(half_period(32'(code)));

  // The counter sits at 0 on the load cycle and the first toggle happens
  // when it has reached the half-period, so the first high edge comes one
  // cycle later than the following edges; after each toggle counting
  // resumes at 1 to give an exact half-period from then on.
  always_comb begin
    cnt_d    = cnt_q;
    buzzer_d = buzzer_q;
    if (load || !run || half == '0) begin
      cnt_d    = '0;
      buzzer_d = 1'b0;
    end else if (cnt_q == half) begin
      cnt_d    = PER_W'(1);
      buzzer_d = ~buzzer_q;
    end else begin
      cnt_d    = cnt_q + PER_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      buzzer_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      buzzer_q <= buzzer_d;
    end
  end

  assign buzzer = buzzer_q;

endmodule

`default_nettype wire

// File: rtl/song_player.sv
// ============================================================================
// Module   : song_player
// Purpose  : Multi-voice buzzer song player. Steps are read from an internal
//            song memory, each step holding one note per channel and a
//            duration in tempo ticks (duration 0 ends the song).
// Ports    : clk, rst (async, active high), tempo (tick), start, stop, loop,
//            wr_en/wr_addr/wr_data (song memory write, IDLE only),
//            buzzer[CHANNELS], busy, done (end-of-song pulse), pos (step)
// Options  : SONG_PLAYER_LOOP_EN - when defined, loop restarts the song at
//            its end instead of pulsing done.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module song_player #(
  parameter  int CHANNELS = 2,
  parameter  int DEPTH    = 64,
  parameter  int NOTE_W   = 6,
  parameter  int DUR_W    = 8,
  parameter  int PER_W    = 16,
  localparam int AW       = $clog2(DEPTH),
  localparam int WORD_W   = CHANNELS * NOTE_W + DUR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tempo,
  input  logic                start,
  input  logic                stop,
  input  logic                loop,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [WORD_W-1:0]   wr_data,
  output logic [CHANNELS-1:0] buzzer,
  output logic                busy,
  output logic                done,
  output logic [AW-1:0]       pos
);
  import song_pkg::*;

  state_t                     state_d, state_q;
  logic                       fetch_ph_d, fetch_ph_q;
  logic [AW-1:0]              pos_d, pos_q;
  logic [DUR_W-1:0]           dur_d, dur_q;
  logic [CHANNELS*NOTE_W-1:0] note_d, note_q;
  logic                       done_d, done_q;
  logic                       busy_d, busy_q;
  logic                       load_w, run_w, song_end_w, loop_en;

  logic [WORD_W-1:0]          mem [DEPTH];
  logic [WORD_W-1:0]          rd_d, rd_q;
  logic [DUR_W-1:0]           rd_dur;
  logic [CHANNELS*NOTE_W-1:0] rd_notes;

`ifdef SONG_PLAYER_LOOP_EN
  assign loop_en = loop;
`else
  logic unused_loop;
  assign unused_loop = loop;
  assign loop_en     = 1'b0;
`endif

  // Synchronous-read song memory: address in the first FETCH cycle, data
  // available for latching in the second.
  assign rd_d = mem[pos_q];

  always_ff @(posedge clk) begin
    if (wr_en && state_q == ST_IDLE) mem[wr_addr] <= wr_data;
    rd_q <= rd_d;
  end

  assign rd_dur   = rd_q[DUR_W-1:0];
  assign rd_notes = rd_q[WORD_W-1:DUR_W];

  always_comb begin
    state_d    = state_q;
    fetch_ph_d = fetch_ph_q;
    pos_d      = pos_q;
    dur_d      = dur_q;
    note_d     = note_q;
    done_d     = 1'b0;
    load_w     = 1'b0;
    song_end_w = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pos_d      = '0;
          fetch_ph_d = 1'b0;
          state_d    = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (!fetch_ph_q) begin
          fetch_ph_d = 1'b1;
        end else if (rd_dur == '0) begin
          song_end_w = 1'b1;
        end else begin
          dur_d   = rd_dur;
          note_d  = rd_notes;
          load_w  = 1'b1;
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (tempo) begin
          if (dur_q == DUR_W'(1)) begin
            // The last step ends the song here rather than wrapping pos.
            if (pos_q == AW'(DEPTH - 1)) begin
              song_end_w = 1'b1;
            end else begin
              pos_d      = pos_q + AW'(1);
              fetch_ph_d = 1'b0;
              state_d    = ST_FETCH;
            end
          end else begin
            dur_d = dur_q - DUR_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (song_end_w) begin
      if (loop_en) begin
        pos_d      = '0;
        fetch_ph_d = 1'b0;
        state_d    = ST_FETCH;
      end else begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
    end

    // stop overrides everything decided above, including a start.
    if (stop) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
      load_w  = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // Voices look at the next state so they go quiet on the same edge the
  // FSM leaves PLAY.
  assign run_w = (state_d == ST_PLAY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fetch_ph_q <= 1'b0;
      pos_q      <= '0;
      dur_q      <= '0;
      note_q     <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_ph_q <= fetch_ph_d;
      pos_q      <= pos_d;
      dur_q      <= dur_d;
      note_q     <= note_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_voice
    tone_gen #(
      .NOTE_W (NOTE_W),
      .PER_W  (PER_W)
    ) u_tone (
      .clk    (clk),
      .rst    (rst),
      .load   (load_w),
      .run    (run_w),
      .code   (note_q[c*NOTE_W +: NOTE_W]),
      .buzzer (buzzer[c])
    );
  end

  assign busy = busy_q;
  assign done = done_q;
  assign pos  = pos_q;

endmodule

`default_nettype wire

// File: tb/tb_song_player.sv
// ============================================================================
// Module   : tb_song_player
// Purpose  : Self-checking bench for song_player (default parameters).
//            Tone timing is driven from a table of note codes with their
//            hand-computed half-periods; FSM corner cases use short directed
//            sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_song_player;

  logic        clk = 1'b0;
  logic        rst;
  logic        tempo, start, stop, loop, wr_en;
  logic [5:0]  wr_addr;
  logic [19:0] wr_data;
  logic [1:0]  buzzer;
  logic        busy, done;
  logic [5:0]  pos;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  song_player dut (
    .clk     (clk),
    .rst     (rst),
    .tempo   (tempo),
    .start   (start),
    .stop    (stop),
    .loop    (loop),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .buzzer  (buzzer),
    .busy    (busy),
    .done    (done),
    .pos     (pos)
  );

  typedef struct {
    int c0;
    int c1;
    int h0;
    int h1;
  } tone_vec_t;

  tone_vec_t vecs [4];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_step(input int addr, input int n0, input int n1, input int dur);
    wr_en   = 1'b1;
    wr_addr = 6'(addr);
    wr_data = {6'(n1), 6'(n0), 8'(dur)};
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic pulse_tempo();
    tempo = 1'b1;
    tick();
    tempo = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  // Starts playback and records, in cycles after the start edge, the first
  // rise and fall of buzzer[0] and the first rise of buzzer[1] (0 = none).
  task automatic measure(input int limit, output int r0, output int f0, output int r1);
    logic [1:0] prev;
    r0 = 0; f0 = 0; r1 = 0;
    do_start();
    prev = buzzer;
    for (int n = 1; n <= limit; n++) begin
      tick();
      if (buzzer[0] && !prev[0] && r0 == 0) r0 = n;
      if (!buzzer[0] && prev[0] && f0 == 0) f0 = n;
      if (buzzer[1] && !prev[1] && r1 == 0) r1 = n;
      prev = buzzer;
    end
  endtask

  initial begin
    int r0, f0, r1, lim, errs, ndone, nrise;
    int seq [4];
    logic prev0;

    vecs[0] = '{c0: 1,  c1: 0,  h0: 4727, h1: 0};
    vecs[1] = '{c0: 2,  c1: 13, h0: 4462, h1: 2364};
    vecs[2] = '{c0: 25, c1: 49, h0: 1182, h1: 295};
    vecs[3] = '{c0: 63, c1: 0,  h0: 132,  h1: 0};

    rst = 1'b1; tempo = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    tick(); tick();
    check("reset_buzzer", int'(buzzer), 0);
    check("reset_busy",   int'(busy),   0);
    check("reset_done",   int'(done),   0);
    check("reset_pos",    int'(pos),    0);
    rst = 1'b0;
    tick();

    // Tone timing table: first rise at 3+H, first fall at 3+2H.
    foreach (vecs[i]) begin
      write_step(0, vecs[i].c0, vecs[i].c1, 1);
      lim = 3 + 2 * ((vecs[i].h0 > vecs[i].h1) ? vecs[i].h0 : vecs[i].h1) + 4;
      measure(lim, r0, f0, r1);
      check($sformatf("tone%0d_rise0", i), r0, 3 + vecs[i].h0);
      check($sformatf("tone%0d_fall0", i), f0, 3 + 2 * vecs[i].h0);
      check($sformatf("tone%0d_rise1", i), r1, (vecs[i].h1 == 0) ? 0 : 3 + vecs[i].h1);
      check($sformatf("tone%0d_busy", i), int'(busy), 1);
      do_stop();
      check($sformatf("tone%0d_stop_busy", i), int'(busy), 0);
      check($sformatf("tone%0d_stop_buzzer", i), int'(buzzer), 0);
    end

    // Two-step song ending on a duration-0 marker.
    write_step(0, 1, 0, 2);
    write_step(1, 0, 0, 0);
    measure(4735, r0, f0, r1);
    check("song_rise0", r0, 4730);
    check("song_rise1", r1, 0);
    pulse_tempo();
    check("song_after_t1_busy", int'(busy), 1);
    pulse_tempo();
    check("song_after_t2_buzzer", int'(buzzer), 0);
    check("song_after_t2_done", int'(done), 0);
    tick();
    check("song_t2p1_done", int'(done), 0);
    tick();
    check("song_t2p2_done", int'(done), 1);
    check("song_t2p2_busy", int'(busy), 0);
    check("song_t2p2_pos",  int'(pos),  1);
    tick();
    check("song_done_pulse_len", int'(done), 0);

    // tempo held high through FETCH cycles must only count in PLAY.
    write_step(0, 1, 0, 1);
    write_step(1, 1, 0, 2);
    write_step(2, 0, 0, 0);
    do_start();
    tempo = 1'b1;
    repeat (5) tick();
    check("fetch_tick_pos",  int'(pos),  1);
    check("fetch_tick_busy", int'(busy), 1);
    repeat (4) tick();
    tempo = 1'b0;
    check("fetch_tick_done", int'(done), 1);
    check("fetch_tick_end_pos", int'(pos), 2);

    // Full memory of 1-tick steps: end at pos 63 without wrapping.
    for (int a = 0; a < 64; a++) write_step(a, 2, 0, 1);
    do_start();
    tick(); tick();
    errs = 0; ndone = 0;
    for (int k = 0; k < 63; k++) begin
      pulse_tempo();
      if (done) ndone++;
      tick();
      if (done) ndone++;
      tick();
      if (done) ndone++;
      if (int'(pos) != k + 1) errs++;
    end
    check("walk_pos_errors", errs, 0);
    check("walk_early_done", ndone, 0);
    pulse_tempo();
    check("walk_end_done", int'(done), 1);
    check("walk_end_pos",  int'(pos),  63);
    check("walk_end_busy", int'(busy), 0);
    tick();
    check("walk_after_done", int'(done), 0);
    check("walk_after_pos",  int'(pos),  63);

    // Two-step song with loop requested; pos sampled at each buzzer rise.
    loop = 1'b1;
    write_step(0, 61, 0, 1);
    write_step(1, 61, 0, 1);
    write_step(2, 0, 0, 0);
    for (int i = 0; i < 4; i++) seq[i] = -1;
    do_start();
    nrise = 0; ndone = 0; prev0 = buzzer[0];
    for (int n = 1; n <= 1700; n++) begin
      tempo = (n % 400 == 399);
      tick();
      tempo = 1'b0;
      if (done) ndone++;
      if (buzzer[0] && !prev0) begin
        if (nrise < 4) seq[nrise] = int'(pos);
        nrise++;
      end
      prev0 = buzzer[0];
    end
`ifdef SONG_PLAYER_LOOP_EN
    check("loop_rises", nrise, 4);
    check("loop_seq0", seq[0], 0);
    check("loop_seq1", seq[1], 1);
    check("loop_seq2", seq[2], 0);
    check("loop_seq3", seq[3], 1);
    check("loop_done_count", ndone, 0);
`else
    check("noloop_rises", nrise, 2);
    check("noloop_seq0", seq[0], 0);
    check("noloop_seq1", seq[1], 1);
    check("noloop_done_count", ndone, 1);
`endif
    do_stop();
    loop = 1'b0;

    // stop and start together mid-PLAY.
    write_step(0, 63, 0, 5);
    do_start();
    repeat (140) tick();
    check("stopstart_pre_buzzer", int'(buzzer), 1);
    stop = 1'b1; start = 1'b1;
    tick();
    stop = 1'b0; start = 1'b0;
    check("stopstart_busy",   int'(busy),   0);
    check("stopstart_buzzer", int'(buzzer), 0);
    tick();
    check("stopstart_stays_idle", int'(busy), 0);

    // Writes during PLAY are ignored.
    write_step(0, 25, 0, 3);
    write_step(1, 0, 0, 0);
    do_start();
    repeat (10) tick();
    write_step(0, 0, 63, 1);
    repeat (3) pulse_tempo();
    tick(); tick();
    check("wrplay_done", int'(done), 1);
    measure(1190, r0, f0, r1);
    check("wrplay_reread_rise0", r0, 1185);
    check("wrplay_reread_rise1", r1, 0);
    do_stop();

    // Asynchronous reset mid-note, then replay from step 0.
    write_step(0, 63, 0, 1);
    write_step(1, 63, 0, 10);
    write_step(2, 0, 0, 0);
    do_start();
    tick(); tick();
    pulse_tempo();
    repeat (142) tick();
    check("rst_pre_pos",    int'(pos),    1);
    check("rst_pre_buzzer", int'(buzzer), 1);
    rst = 1'b1;
    #1;
    check("rst_mid_buzzer", int'(buzzer), 0);
    check("rst_mid_busy",   int'(busy),   0);
    check("rst_mid_pos",    int'(pos),    0);
    check("rst_mid_done",   int'(done),   0);
    tick();
    rst = 1'b0;
    tick();
    measure(270, r0, f0, r1);
    check("rst_replay_rise0", r0, 135);
    check("rst_replay_fall0", f0, 267);
    check("rst_replay_pos", int'(pos), 0);
    do_stop();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
